switch_conditioner: RTL

//   Conditions the raw Basys3 slide-switch bank before it reaches io_controller.

---
 rtl/basys3_io_pkg.sv | 5 +
 rtl/switch_conditioner_debounce_bit.sv | 60 ++++++
 rtl/switch_conditioner.sv | 71 +++++++
 3 files changed

// File: rtl/basys3_io_pkg.sv
// Board-level constants shared by the Basys3 I/O conditioning blocks.
package basys3_io_pkg;
  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
  localparam int unsigned SW_COUNT       = 16;
endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch bit: synchroniser chain, tick-qualified stability counter,
// clean level and registered rise/fall pulses.
module debounce_bit #(
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_update
);

  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_mismatch;
  logic                   w_last;
  logic                   w_update;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_mismatch = w_s ^ r_clean;
  assign w_last     = (r_cnt == CW'(STABLE_TICKS - 1));
  // Asserted in the cycle before clean/rise/fall change, so the top can
  // register any_change in step with the per-bit pulses.
  assign w_update   = i_tick & w_mismatch & w_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_rise <= w_update & w_s;
      r_fall <= w_update & ~w_s;
      if (i_tick) begin
        if (!w_mismatch || w_last) r_cnt <= '0;
        else                       r_cnt <= r_cnt + 1'b1;
        if (w_update) r_clean <= w_s;
      end
    end
  end

  assign o_clean  = r_clean;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_update = w_update;

endmodule

// File: rtl/switch_conditioner.sv
// Slide-switch conditioner: shared sample prescaler plus one debounce_bit
// per input; clean_out feeds io_controller.sw.
module switch_conditioner
  import basys3_io_pkg::*;
#(
  parameter int unsigned N_IN         = SW_COUNT,
  parameter int unsigned CLK_HZ       = CLK_HZ_DEFAULT,
  parameter int unsigned TICK_HZ      = 1_000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] clean_out,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  output logic            any_change,
  output logic            tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("switch_conditioner: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable
    $error("switch_conditioner: STABLE_TICKS must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("switch_conditioner: SYNC_STAGES must be at least 2");
  end

  logic [PW-1:0]   r_presc;
  logic            r_any_change;
  logic            w_tick;
  logic [N_IN-1:0] w_update;

  assign w_tick = (r_presc == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_presc      <= '0;
      r_any_change <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + 1'b1;
      r_any_change <= |w_update;
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_debounce_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .i_tick  (w_tick),
      .i_raw   (raw_in[i]),
      .o_clean (clean_out[i]),
      .o_rise  (rise[i]),
      .o_fall  (fall[i]),
      .o_update(w_update[i])
    );
  end

  assign any_change = r_any_change;
  assign tick       = w_tick;

endmodule
